// File: rtl/snake_dir_input.sv
// Button front end for the snake game: sync + debounce four buttons, queue heading changes.
// Define DIR_DEBOUNCE_BYPASS_EN to drop the debouncers (press = edge of synchronized level).
module snake_dir_input #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int QUEUE_DEPTH     = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       BtnU,
    input  logic       BtnR,
    input  logic       BtnD,
    input  logic       BtnL,
    input  logic       Tick,
    output logic [1:0] Dir,
    output logic       DirChg,
    output logic [2:0] QCount,
    output logic       Overflow
);

    localparam int PW = $clog2(QUEUE_DEPTH);

    // Bit order {U, R, D, L}: index 3 has highest priority.
    logic [3:0] raw, sync1, sync2, level, level_d, press;

    assign raw = {BtnU, BtnR, BtnD, BtnL};

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync1   <= '0;
            sync2   <= '0;
            level_d <= '0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_d <= level;
        end
    end

`ifdef DIR_DEBOUNCE_BYPASS_EN
    assign level = sync2;
`else
    logic [CNT_W-1:0] db_cnt [4];
    logic [3:0]       accepted;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            accepted <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == accepted[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    accepted[i] <= ~accepted[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign level = accepted;
`endif

    assign press = level & ~level_d;

    logic [1:0]    q [QUEUE_DEPTH];
    logic [PW-1:0] head, tail_idx, wr_idx;
    logic [2:0]    count, cnt_pop;
    logic          pop, push, drop, pvalid, valid;
    logic [1:0]    pdir, ref_dir;

    always_comb begin
        pvalid = 1'b1;
        pdir   = 2'b00;
        if (press[3])      pdir = 2'b00;
        else if (press[2]) pdir = 2'b01;
        else if (press[1]) pdir = 2'b10;
        else if (press[0]) pdir = 2'b11;
        else               pvalid = 1'b0;
    end

    // The reference heading is whatever the snake will be facing once everything queued is applied.
    always_comb begin
        pop      = Tick && (count != 3'd0);
        cnt_pop  = count - {2'b00, pop};
        tail_idx = head + PW'(count - 3'd1);
        wr_idx   = head + PW'(count);
        if (cnt_pop != 3'd0) ref_dir = q[tail_idx];
        else if (pop)        ref_dir = q[head];
        else                 ref_dir = Dir;
        valid = pvalid && (pdir != ref_dir) && (pdir != (ref_dir ^ 2'b10));
        push  = valid && (cnt_pop != 3'(QUEUE_DEPTH));
        drop  = valid && !push;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Dir      <= 2'b01;
            head     <= '0;
            count    <= '0;
            DirChg   <= 1'b0;
            Overflow <= 1'b0;
            for (int i = 0; i < QUEUE_DEPTH; i++) q[i] <= 2'b00;
        end else begin
            if (pop) begin
                Dir  <= q[head];
                head <= head + PW'(1);
            end
            // When full and popping, wr_idx lands on the slot being freed.
            if (push) q[wr_idx] <= pdir;
            count    <= cnt_pop + {2'b00, push};
            DirChg   <= pop;
            Overflow <= drop;
        end
    end

    assign QCount = count;

endmodule

// File: tb/tb_snake_dir_input.sv
// Bench for snake_dir_input with a short debounce; expected headings queued per Tick.
module tb_snake_dir_input;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       BtnU = 1'b0, BtnR = 1'b0, BtnD = 1'b0, BtnL = 1'b0;
    logic       Tick = 1'b0;
    logic [1:0] Dir;
    logic       DirChg;
    logic [2:0] QCount;
    logic       Overflow;

    int checks = 0;
    int errors = 0;
    logic [1:0] sb [$];

    localparam logic [3:0] M_U = 4'b1000, M_R = 4'b0100, M_D = 4'b0010, M_L = 4'b0001;

    snake_dir_input #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .QUEUE_DEPTH(2)) dut (
        .Clk(Clk), .Reset(Reset), .BtnU(BtnU), .BtnR(BtnR), .BtnD(BtnD), .BtnL(BtnL),
        .Tick(Tick), .Dir(Dir), .DirChg(DirChg), .QCount(QCount), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Every DirChg pulse must match the next heading the bench expected.
    always @(negedge Clk) begin
        if (DirChg) begin
            if (sb.size() == 0) chk("dirchg_unexpected", 1, 0);
            else chk("dir_after_tick", int'(Dir), int'(sb.pop_front()));
        end
    end

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("rst_dir", int'(Dir), 1);
        chk("rst_qcount", int'(QCount), 0);
    endtask

    task automatic tick(input logic expect_pop, input logic [1:0] d);
        Tick = 1'b1;
        if (expect_pop) sb.push_back(d);
        @(negedge Clk);
        Tick = 1'b0;
        @(negedge Clk);
        chk("dirchg_width", int'(DirChg), 0);
    endtask

    // Press lands on the 6th negedge after driving; QCount/Overflow update on the 7th.
    task automatic press(input logic [3:0] mask, input int pre_q, input int exp_q,
                         input logic exp_ovf, input logic do_tick, input logic [1:0] tdir);
        {BtnU, BtnR, BtnD, BtnL} = mask;
        repeat (6) @(negedge Clk);
        chk("q_before_press", int'(QCount), pre_q);
        if (do_tick) begin
            Tick = 1'b1;
            sb.push_back(tdir);
        end
        @(negedge Clk);
        Tick = 1'b0;
        chk("q_after_press", int'(QCount), exp_q);
        chk("overflow", int'(Overflow), int'(exp_ovf));
        @(negedge Clk);
        chk("overflow_width", int'(Overflow), 0);
        repeat (4) @(negedge Clk);
        {BtnU, BtnR, BtnD, BtnL} = 4'b0000;
        repeat (10) @(negedge Clk);
        chk("q_held_once", int'(QCount), exp_q);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (10) @(negedge Clk);
        chk("idle_dir", int'(Dir), 1);
        chk("idle_qcount", int'(QCount), 0);
        chk("idle_dirchg", int'(DirChg), 0);
        chk("idle_overflow", int'(Overflow), 0);

        // Held BtnD: exactly one press, then Tick applies DOWN.
        press(M_D, 0, 1, 1'b0, 1'b0, 2'b00);
        tick(1'b1, 2'b10);
        chk("q_after_pop", int'(QCount), 0);
        tick(1'b0, 2'b00);
        chk("empty_tick_dir", int'(Dir), 2);

        // Bouncing BtnD never stays stable long enough.
        for (int i = 0; i < 10; i++) begin
            BtnD = 1'b1;
            repeat (3) @(negedge Clk);
            BtnD = 1'b0;
            @(negedge Clk);
        end
        repeat (10) @(negedge Clk);
        chk("glitch_qcount", int'(QCount), 0);

        do_reset();
        press(M_L, 0, 0, 1'b0, 1'b0, 2'b00);
        press(M_R, 0, 0, 1'b0, 1'b0, 2'b00);
        press(M_U, 0, 1, 1'b0, 1'b0, 2'b00);
        press(M_L, 1, 2, 1'b0, 1'b0, 2'b00);
        tick(1'b1, 2'b00);
        tick(1'b1, 2'b11);
        chk("q_drained", int'(QCount), 0);

        // Full queue: DOWN overflows; with a same-cycle Tick it fills the freed slot.
        do_reset();
        press(M_U, 0, 1, 1'b0, 1'b0, 2'b00);
        press(M_L, 1, 2, 1'b0, 1'b0, 2'b00);
        press(M_D, 2, 2, 1'b1, 1'b0, 2'b00);
        do_reset();
        press(M_U, 0, 1, 1'b0, 1'b0, 2'b00);
        press(M_L, 1, 2, 1'b0, 1'b0, 2'b00);
        press(M_D, 2, 2, 1'b0, 1'b1, 2'b00);
        tick(1'b1, 2'b11);
        tick(1'b1, 2'b10);
        chk("q_drained2", int'(QCount), 0);

        // Simultaneous U+L keeps U; reset discards a pending entry.
        do_reset();
        press(M_U | M_L, 0, 1, 1'b0, 1'b0, 2'b00);
        do_reset();
        press(M_U | M_L, 0, 1, 1'b0, 1'b0, 2'b00);
        tick(1'b1, 2'b00);

        // Reset mid-debounce with BtnR... from Dir=00 use BtnL held across reset (Dir back to 01 -> use U).
        do_reset();
        BtnU = 1'b1;
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        chk("redebounce_early", int'(QCount), 0);
        @(negedge Clk);
        chk("redebounce_press", int'(QCount), 1);
        BtnU = 1'b0;
        repeat (10) @(negedge Clk);
        chk("redebounce_once", int'(QCount), 1);
        tick(1'b1, 2'b00);

        repeat (3) @(negedge Clk);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
